// File: rtl/isa_pkg.sv
// Shared ISA definitions: field positions/widths, ALU opcodes and helpers.
// Used by the instruction encoder and the matching decoder.
package isa_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned PAD_W   = 9;
  localparam int unsigned FN_W    = 5;

  localparam int unsigned OP_LSB  = 29;
  localparam int unsigned RS1_LSB = 24;
  localparam int unsigned RS2_LSB = 19;
  localparam int unsigned RD_LSB  = 14;
  localparam int unsigned PAD_LSB = 5;
  localparam int unsigned FN_LSB  = 0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SHLI = 3'b111
  } alu_op_e;

  // Immediate-carrying operations: only these place imm[4:0] in the function field.
  function automatic logic is_imm_op(input logic [OP_W-1:0] op);
    logic r;
    case (op)
      ALU_ADDI: r = 1'b1;
      ALU_SHLI: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  // The immediate fits the function field only if all upper bits are clear.
  function automatic logic imm_in_range(input logic [IMM_W-1:0] imm);
    return (imm[IMM_W-1:FN_W] == {(IMM_W-FN_W){1'b0}});
  endfunction

  // Pack one instruction word; the immediate is truncated to the function field.
  function automatic logic [INSTR_W-1:0] encode(
    input logic [OP_W-1:0]  op,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic [REG_W-1:0] rd,
    input logic [FN_W-1:0]  imm_lo
  );
    logic [INSTR_W-1:0] w;
    w = {INSTR_W{1'b0}};
    w[OP_LSB  +: OP_W]  = op;
    w[RS1_LSB +: REG_W] = rs1;
    w[RS2_LSB +: REG_W] = rs2;
    w[RD_LSB  +: REG_W] = rd;
    w[PAD_LSB +: PAD_W] = {PAD_W{1'b0}};
    w[FN_LSB  +: FN_W]  = is_imm_op(op) ? imm_lo : {FN_W{1'b0}};
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flop storage, async active-low reset and synchronous flush.
// Head entry is read straight from the storage flops, so it is registered.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_s;
  logic             pop_s;

  // Refuse to overflow or underflow regardless of what the caller requests.
  assign push_s = push && (count_q != CW'(DEPTH));
  assign pop_s  = pop  && (count_q != {CW{1'b0}});

  // Occupancy next-state: flush wins, push+pop together leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {CW{1'b0}};
    end else if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else if (flush) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs ALU field tuples into 32-bit words, tags each
// with a sequence address and buffers them in a small FIFO.
// Optional immediate range check enabled by macro INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         alu_op,
  input  logic [REG_W-1:0]        rs1,
  input  logic [REG_W-1:0]        rs2,
  input  logic [REG_W-1:0]        rd,
  input  logic [IMM_W-1:0]        imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_W-1:0]      instr,
  output logic [AW-1:0]           instr_addr,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned FW = INSTR_W + AW;

  logic [AW-1:0]      addr_q;
  logic [AW-1:0]      addr_d;
  logic [INSTR_W-1:0] enc_s;
  logic               range_bad_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic [FW-1:0]      rdata_s;
  logic [CW-1:0]      count_s;

  assign enc_s = encode(alu_op, rs1, rs2, rd, imm[FN_W-1:0]);

  // Handshake depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_s < CW'(DEPTH));
  assign out_valid = (count_s != {CW{1'b0}});
  assign accept_s  = in_valid && in_ready && !flush;
  assign push_s    = accept_s && !range_bad_s;
  assign pop_s     = out_valid && out_ready && !flush;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic err_q;
  logic err_d;

  assign range_bad_s = is_imm_op(alu_op) && !imm_in_range(imm);

  // Sticky error: set by a rejected tuple, cleared only by flush or reset.
  always_comb begin
    err_d = err_q;
    if (flush) begin
      err_d = 1'b0;
    end else if (accept_s && range_bad_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic imm_hi_unused_s;

  // Upper immediate bits are simply dropped in this build.
  assign imm_hi_unused_s = ^imm[IMM_W-1:FN_W];
  assign range_bad_s     = 1'b0;
  assign err             = 1'b0;
`endif

  // Sequence address: advances only on buffered words, wraps modulo 2^AW.
  always_comb begin
    addr_d = addr_q;
    if (flush) begin
      addr_d = {AW{1'b0}};
    end else if (push_s) begin
      addr_d = addr_q + AW'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= {AW{1'b0}};
    end else begin
      addr_q <= addr_d;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_s),
    .wdata ({addr_q, enc_s}),
    .pop   (pop_s),
    .rdata (rdata_s),
    .count (count_s)
  );

  assign instr      = rdata_s[INSTR_W-1:0];
  assign instr_addr = rdata_s[FW-1:INSTR_W];
  assign count      = count_s;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder (default DEPTH=4, AW=8).
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [7:0]  instr_addr;
  logic [2:0]  count;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .instr_addr (instr_addr),
    .count      (count),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_tuple(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic [31:0] im);
    alu_op = op;
    rs1    = a;
    rs2    = b;
    rd     = d;
    imm    = im;
  endtask

  initial begin
    logic [31:0] exp_w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_tuple(3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", 32'(instr_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic register op, one-cycle latency
    set_tuple(3'b000, 5'd1, 5'd2, 5'd3, 32'd9);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_instr", instr, 32'h0110C000);
    chk("t1_addr", 32'(instr_addr), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t1_pop_count", 32'(count), 32'd0);
    chk("t1_pop_valid", 32'(out_valid), 32'd0);

    // Immediate op
    set_tuple(3'b110, 5'd5, 5'd0, 5'd7, 32'd9);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t2_instr", instr, 32'hC501C009);
    chk("t2_addr", 32'(instr_addr), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Fill to full with out_ready low, then drain in order
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t3_flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      set_tuple(3'b000, 5'(i + 1), 5'd0, 5'(i + 1), 32'd0);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_full_in_ready", 32'(in_ready), 32'd0);
    chk("t3_head_addr", 32'(instr_addr), 32'd0);
    @(negedge clk);
    chk("t3_hold_addr", 32'(instr_addr), 32'd0);
    chk("t3_hold_instr", instr, 32'h01004000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w = (32'(i + 1) << 24) | (32'(i + 1) << 14);
      chk("t3_drain_addr", 32'(instr_addr), 32'(i));
      chk("t3_drain_instr", instr, exp_w);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("t3_empty_count", 32'(count), 32'd0);
    chk("t3_empty_valid", 32'(out_valid), 32'd0);

    // Out-of-range immediate
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_tuple(3'b111, 5'd0, 5'd0, 5'd1, 32'd32);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef INSTR_ENC_RANGE_CHECK_EN
    chk("t4_rej_count", 32'(count), 32'd0);
    chk("t4_rej_valid", 32'(out_valid), 32'd0);
    chk("t4_err", 32'(err), 32'd1);
    set_tuple(3'b000, 5'd0, 5'd0, 5'd2, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_next_addr", 32'(instr_addr), 32'd0);
    chk("t4_next_instr", instr, 32'h00008000);
    chk("t4_err_sticky", 32'(err), 32'd1);
`else
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_instr", instr, 32'hE0004000);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_addr", 32'(instr_addr), 32'd0);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Stream 257 words with push+pop every cycle: address wraps 255 -> 0
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_err_cleared", 32'(err), 32'd0);
    set_tuple(3'b001, 5'd1, 5'd1, 5'd1, 32'd0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      @(negedge clk);
      chk("t5_stream_addr", 32'(instr_addr), 32'(k % 256));
      chk("t5_stream_count", 32'(count), 32'd1);
    end
    flush = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5_flush_count", 32'(count), 32'd0);
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    set_tuple(3'b000, 5'd0, 5'd0, 5'd5, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_post_flush_addr", 32'(instr_addr), 32'd0);
    chk("t5_post_flush_count", 32'(count), 32'd1);

    // Reset mid-operation with three words buffered
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("t6_pre_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_instr", instr, 32'd0);
    chk("t6_rst_addr", 32'(instr_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_no_stale", 32'(out_valid), 32'd0);
    set_tuple(3'b000, 5'd3, 5'd0, 5'd9, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t6_first_addr", 32'(instr_addr), 32'd0);
    chk("t6_first_instr", instr, 32'h03024000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
